// File: rtl/pmc_pkg.sv
// Shared constants and the readout FSM state type for the PMC snapshot readout.
package pmc_pkg;

    // Stream word width and performance counter geometry
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 256;
    localparam int NUM_CNT = 4;

    // Header magic and frame length (one header plus 32 data words)
    localparam logic [15:0] HDR_MAGIC = 16'hC0DE;
    localparam int          FRAME_LEN = 33;

    // Index of the final data word within a frame
    localparam logic [4:0] LAST_IDX = 5'd31;

    // Readout sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Builds the frame header word from the current frame number and overrun flag
    function automatic logic [31:0] makeHeader(input logic [7:0] frameId, input logic overrunFlag);
        makeHeader = {HDR_MAGIC, frameId, overrunFlag, 7'(FRAME_LEN)};
    endfunction

endpackage

// File: rtl/pmc_word_mux.sv
// Combinational word selector: picks one WORD_W-wide slice of the snapshot
// shadow register, word 0 being the least-significant slice.
module pmc_word_mux
    import pmc_pkg::*;
#(
    parameter int MUX_WORD_W   = 32,
    parameter int MUX_SHADOW_W = 1024
) (
    input  logic [MUX_SHADOW_W-1:0] i_shadow,
    input  logic [4:0]              i_idx,
    output logic [MUX_WORD_W-1:0]   o_word
);

    // Word i occupies bits [i*WORD_W +: WORD_W] of the shadow
    always_comb begin
        o_word = i_shadow[int'(i_idx)*MUX_WORD_W +: MUX_WORD_W];
    end

endmodule

// File: rtl/pmc_readout.sv
// Performance-counter snapshot readout. A snapshot request in IDLE captures all
// counters into a shadow register, then the block streams a header word followed
// by the shadow contents (stall, CPI, arith, mem; least-significant word first)
// over a valid/ready interface. Requests arriving while a frame is in flight are
// dropped and remembered in a sticky overrun flag.
module pmc_readout
    import pmc_pkg::*;
#(
    parameter int WORD_W  = pmc_pkg::WORD_W,
    parameter int CNT_W   = pmc_pkg::CNT_W,
    parameter int NUM_CNT = pmc_pkg::NUM_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snap_req,
    input  logic [CNT_W-1:0]  stall_count,
    input  logic [CNT_W-1:0]  cycles_per_instruction_q78,
    input  logic [CNT_W-1:0]  arith_count,
    input  logic [CNT_W-1:0]  mem_access_count,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        frame_id,
    output logic              overrun
);

    localparam int SHADOW_W = NUM_CNT * CNT_W;

    // Registered state
    state_t              r_state;
    logic [4:0]          r_idx;
    logic [SHADOW_W-1:0] r_shadow;
    logic [7:0]          r_frameId;
    logic                r_overrun;
    logic                r_valid;
    logic [WORD_W-1:0]   r_data;
    logic                r_last;

    // Next-state values
    state_t              w_stateNext;
    logic [4:0]          w_idxNext;
    logic [SHADOW_W-1:0] w_shadowNext;
    logic [7:0]          w_frameIdNext;
    logic                w_overrunNext;
    logic                w_validNext;
    logic [WORD_W-1:0]   w_dataNext;
    logic                w_lastNext;

    // Datapath helpers
    logic                w_fire;
    logic [4:0]          w_selIdx;
    logic [WORD_W-1:0]   w_muxWord;
    logic [WORD_W-1:0]   w_header;
    logic [SHADOW_W-1:0] w_capture;

    assign w_fire    = r_valid & out_ready;
    assign w_header  = WORD_W'(makeHeader(r_frameId, r_overrun));
    assign w_capture = SHADOW_W'({mem_access_count, arith_count,
                                  cycles_per_instruction_q78, stall_count});

    // The word loaded on a transfer is always the one after the current index;
    // leaving the header it is word 0.
    assign w_selIdx = (r_state == DATA) ? (r_idx + 5'd1) : 5'd0;

    pmc_word_mux #(
        .MUX_WORD_W   (WORD_W),
        .MUX_SHADOW_W (SHADOW_W)
    ) u_wordMux (
        .i_shadow (r_shadow),
        .i_idx    (w_selIdx),
        .o_word   (w_muxWord)
    );

    // Next-state and next-output decode; outputs are registered so valid rises one cycle after capture
    always_comb begin
        w_stateNext   = r_state;
        w_idxNext     = r_idx;
        w_shadowNext  = r_shadow;
        w_frameIdNext = r_frameId;
        w_overrunNext = r_overrun | (snap_req & (r_state != IDLE));
        w_validNext   = r_valid;
        w_dataNext    = r_data;
        w_lastNext    = r_last;

        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_stateNext  = HDR;
                    w_shadowNext = w_capture;
                    w_idxNext    = 5'd0;
                    w_validNext  = 1'b1;
                    w_dataNext   = w_header;
                    w_lastNext   = 1'b0;
                end
            end
            HDR: begin
                if (w_fire) begin
                    w_stateNext = DATA;
                    w_idxNext   = 5'd0;
                    w_dataNext  = w_muxWord;
                    w_lastNext  = 1'b0;
                end
            end
            DATA: begin
                if (w_fire) begin
                    if (r_last) begin
                        w_stateNext   = IDLE;
                        w_idxNext     = 5'd0;
                        w_validNext   = 1'b0;
                        w_dataNext    = '0;
                        w_lastNext    = 1'b0;
                        w_frameIdNext = r_frameId + 8'd1;
                    end else begin
                        w_idxNext  = r_idx + 5'd1;
                        w_dataNext = w_muxWord;
                        w_lastNext = ((r_idx + 5'd1) == LAST_IDX);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_validNext = 1'b0;
                w_dataNext  = '0;
                w_lastNext  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Shadow, index, frame counter, sticky overrun and registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= 5'd0;
            r_shadow  <= '0;
            r_frameId <= 8'd0;
            r_overrun <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
        end else begin
            r_idx     <= w_idxNext;
            r_shadow  <= w_shadowNext;
            r_frameId <= w_frameIdNext;
            r_overrun <= w_overrunNext;
            r_valid   <= w_validNext;
            r_data    <= w_dataNext;
            r_last    <= w_lastNext;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state != IDLE);
    assign frame_id  = r_frameId;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pmc_readout.sv
// Directed bench for pmc_readout: single frames with steady and toggling ready,
// counter changes after capture, dropped requests, mid-frame reset and frame_id wrap.
module tb_pmc_readout;

    logic         clk;
    logic         reset;
    logic         snap_req;
    logic [255:0] stall_count;
    logic [255:0] cycles_per_instruction_q78;
    logic [255:0] arith_count;
    logic [255:0] mem_access_count;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [7:0]   frame_id;
    logic         overrun;

    int testCount = 0;
    int failCount = 0;
    int cycles;

    pmc_readout dut (
        .clk                        (clk),
        .reset                      (reset),
        .snap_req                   (snap_req),
        .stall_count                (stall_count),
        .cycles_per_instruction_q78 (cycles_per_instruction_q78),
        .arith_count                (arith_count),
        .mem_access_count           (mem_access_count),
        .out_data                   (out_data),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_last                   (out_last),
        .busy                       (busy),
        .frame_id                   (frame_id),
        .overrun                    (overrun)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected when it misses
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives the four counter inputs
    task automatic applyStimulus(input logic [255:0] stall, input logic [255:0] cpi,
                                 input logic [255:0] arith, input logic [255:0] mem);
        stall_count                = stall;
        cycles_per_instruction_q78 = cpi;
        arith_count                = arith;
        mem_access_count           = mem;
    endtask

    // Hand-computed frame contents for stall=5, cpi=0x180, arith=0x64, mem=0xA
    function automatic logic [31:0] expWord(input logic [31:0] hdr, input int k);
        if (k == 0) return hdr;
        case (k - 1)
            0:       return 32'h0000_0005;
            8:       return 32'h0000_0180;
            16:      return 32'h0000_0064;
            24:      return 32'h0000_000A;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // One-cycle snapshot request, issued from a falling edge
    task automatic pulseSnap();
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Consumes nWords words of a frame; checks every presented word, including stalled cycles
    task automatic receiveFrame(input logic [31:0] hdr, input bit toggle, input int snapIdx,
                                input bit snapLast, input int nWords, output int nCycles);
        int k = 0;
        int cyc = 0;
        while (k < nWords && cyc < 200) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            snap_req  = ((snapIdx >= 0) && (k == snapIdx + 1)) || (snapLast && (k == 32) && out_ready);
            if (!out_valid) begin
                checkOutput("validDuringFrame", {31'd0, out_valid}, 32'd1);
                break;
            end
            checkOutput($sformatf("data[%0d]", k), out_data, expWord(hdr, k));
            checkOutput($sformatf("last[%0d]", k), {31'd0, out_last}, {31'd0, (k == 32)});
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        snap_req  = 1'b0;
        out_ready = 1'b1;
        checkOutput("wordsReceived", k, nWords);
        nCycles = cyc;
    endtask

    // Directed test sequence
    initial begin
        reset     = 1'b1;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        applyStimulus('0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstData", out_data, 32'd0);
        checkOutput("rstLast", {31'd0, out_last}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstFrameId", {24'd0, frame_id}, 32'd0);
        checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic frame, ready held high");
        applyStimulus(256'h5, 256'h180, 256'h64, 256'hA);
        out_ready = 1'b1;
        pulseSnap();
        checkOutput("busyAfterSnap", {31'd0, busy}, 32'd1);
        receiveFrame(32'hC0DE0021, 1'b0, -1, 1'b0, 33, cycles);
        checkOutput("idleValid", {31'd0, out_valid}, 32'd0);
        checkOutput("idleData", out_data, 32'd0);
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);
        checkOutput("frameId1", {24'd0, frame_id}, 32'd1);

        $display("[TB] ready toggling every cycle");
        pulseSnap();
        receiveFrame(32'hC0DE0121, 1'b1, -1, 1'b0, 33, cycles);
        checkOutput("toggleCycles", cycles, 66);
        checkOutput("frameId2", {24'd0, frame_id}, 32'd2);

        $display("[TB] counters change after capture");
        pulseSnap();
        applyStimulus('1, '1, '1, '1);
        receiveFrame(32'hC0DE0221, 1'b0, -1, 1'b0, 33, cycles);
        checkOutput("frameId3", {24'd0, frame_id}, 32'd3);
        applyStimulus(256'h5, 256'h180, 256'h64, 256'hA);

        $display("[TB] requests while busy are dropped");
        pulseSnap();
        receiveFrame(32'hC0DE0321, 1'b0, 10, 1'b1, 33, cycles);
        checkOutput("overrunSet", {31'd0, overrun}, 32'd1);
        checkOutput("noSecondBusy", {31'd0, busy}, 32'd0);
        checkOutput("noSecondValid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("stillIdleValid", {31'd0, out_valid}, 32'd0);
        checkOutput("frameId4", {24'd0, frame_id}, 32'd4);
        checkOutput("overrunSticky", {31'd0, overrun}, 32'd1);

        $display("[TB] reset in the middle of a frame");
        pulseSnap();
        receiveFrame(32'hC0DE04A1, 1'b0, -1, 1'b0, 21, cycles);
        checkOutput("preResetValid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRstData", out_data, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstFrameId", {24'd0, frame_id}, 32'd0);
        checkOutput("midRstOverrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortedValid", {31'd0, out_valid}, 32'd0);
        pulseSnap();
        receiveFrame(32'hC0DE0021, 1'b0, -1, 1'b0, 33, cycles);
        checkOutput("postRstFrameId", {24'd0, frame_id}, 32'd1);

        $display("[TB] 256 back-to-back frames");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
            pulseSnap();
            receiveFrame({16'hC0DE, 8'(f), 8'h21}, 1'b0, -1, 1'b0, 33, cycles);
            checkOutput($sformatf("wrapFrameId[%0d]", f), {24'd0, frame_id}, 32'((f + 1) % 256));
        end
        pulseSnap();
        receiveFrame(32'hC0DE0021, 1'b0, -1, 1'b0, 33, cycles);
        checkOutput("frame257Id", {24'd0, frame_id}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pmc_readout.md
PMC_READOUT -- requirements
Module: pmc_readout

Interface
REQ-001 The module SHALL have parameter WORD_W, default 32, meaning the output word width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 256, meaning the width of each performance counter input.
REQ-003 The module SHALL have parameter NUM_CNT, default 4, meaning the number of counters captured per snapshot.
REQ-004 The module SHALL have port clk, input, 1 bit, the single system clock; all state is rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The module SHALL have port snap_req, input, 1 bit, a snapshot request sampled on each rising edge.
REQ-007 The module SHALL have port stall_count, input, CNT_W bits, the stall counter value.
REQ-008 The module SHALL have port cycles_per_instruction_q78, input, CNT_W bits, the CPI value in Q7.8 format.
REQ-009 The module SHALL have port arith_count, input, CNT_W bits, the arithmetic instruction count.
REQ-010 The module SHALL have port mem_access_count, input, CNT_W bits, the memory access count.
REQ-011 The module SHALL have port out_data, output, WORD_W bits, the stream data word.
REQ-012 The module SHALL have port out_valid, output, 1 bit, asserted when out_data holds a valid word.
REQ-013 The module SHALL have port out_ready, input, 1 bit, asserted when the consumer can accept a word.
REQ-014 The module SHALL have port out_last, output, 1 bit, marking the final word of a frame.
REQ-015 The module SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-016 The module SHALL have port frame_id, output, 8 bits, the count of completed frames.
REQ-017 The module SHALL have port overrun, output, 1 bit, a sticky flag recording a dropped request.

Function
REQ-018 The FSM SHALL have three states: IDLE, HDR and DATA.
REQ-019 In IDLE with snap_req=1 at an edge, all four counters SHALL be latched into a NUM_CNT*CNT_W shadow register at that edge, and the state SHALL become HDR.
REQ-020 out_valid SHALL be registered and high from the cycle after the accepted snap_req; the latency is 1 cycle.
REQ-021 A transfer SHALL occur only on an edge where out_valid=1 and out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 The header word in HDR SHALL be laid out as: [31:16]=16'hC0DE, [15:8]=frame_id, [7]=overrun, [6:0]=7'd33.
REQ-024 A transfer in HDR SHALL move the state to DATA with word index 0.
REQ-025 DATA SHALL emit 32 words: stall, then CPI, then arith, then mem; within each counter the least-significant word SHALL come first.
REQ-026 Word index i SHALL select shadow[(i*32)+31 : i*32].
REQ-027 out_last SHALL be 1 only on DATA word index 31.
REQ-028 A transfer with out_last=1 SHALL return the state to IDLE and increment frame_id modulo 256, so 255 wraps to 0.
REQ-029 snap_req=1 while busy=1, including the edge of the last transfer, SHALL be dropped and SHALL set overrun.
REQ-030 overrun SHALL clear only on reset.
REQ-031 The shadow register SHALL be unaffected by counter input changes during a frame.
REQ-032 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-033 Asserting reset SHALL immediately force: state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, frame_id=0, overrun=0, shadow=0, word index=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no further words emitted.
REQ-035 After reset deasserts, the first accepted snap_req SHALL start a new frame with frame_id=0.

Structure
REQ-036 The shared package pmc_pkg SHALL contain WORD_W, CNT_W, NUM_CNT, HDR_MAGIC=16'hC0DE, FRAME_LEN=33 and the state enum typedef.
REQ-037 A combinational word-select sub-module named pmc_word_mux SHALL map the shadow register and a 5-bit index to a 32-bit word; the FSM, shadow register and counters SHALL reside in pmc_readout.

Verification
REQ-038 The bench SHALL drive stall=256'h5, cpi=256'h180, arith=256'h64 and mem=256'hA, pulse snap_req, and hold out_ready=1; the required response is header 32'hC0DE0021, then words 5,0×7, 0x180,0×7, 0x64,0×7, 0xA,0×7; out_last on word 33; frame_id becomes 1.
REQ-039 The bench SHALL toggle out_ready 1/0 every cycle; the required response is the same 33-word sequence with data stable during stalls, occupying 66 cycles.
REQ-040 The bench SHALL change all counter inputs to all-ones right after capture; the required response is that the emitted words still equal the captured values.
REQ-041 The bench SHALL pulse snap_req at DATA word 10, and again on the out_last transfer edge; the required response is that overrun=1, no second frame starts, and the next frame header bit [7]=1.
REQ-042 The bench SHALL assert reset at DATA word 20; the required response is out_valid=0 immediately, frame_id=0, and the next frame header is 32'hC0DE0021.
REQ-043 The bench SHALL run 256 back-to-back frames; the required response is that frame_id wraps to 0 and the header of frame 257 carries frame_id 8'h00.
